// File: rtl/hpu_pkg.sv
// Shared defaults and FSM state type for the HPU candidate loader.
package hpu_pkg;

   localparam int unsigned HPU_DATA_W    = 32;
   localparam int unsigned HPU_ROW_IDX_W = 16;
   localparam int unsigned HPU_MAX_ELEMS = 256;

   typedef enum logic [1:0] {
      StFill,
      StEval,
      StHold
   } hpu_loader_state_e;

endpackage

// File: rtl/hpu_abs_sat.sv
// Saturating absolute value: the most negative input maps to the largest positive value.
module hpu_abs_sat #(
   parameter int unsigned DATA_W = 32
) (
   input  logic signed [DATA_W-1:0] in_val,
   output logic signed [DATA_W-1:0] out_val
);

   localparam logic signed [DATA_W-1:0] MinVal = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [DATA_W-1:0] MaxVal = {1'b0, {(DATA_W-1){1'b1}}};

   always_comb begin
      out_val = in_val;
      if (in_val == MinVal) begin
         out_val = MaxVal;
      end else if (in_val[DATA_W-1]) begin
         out_val = -in_val;
      end
   end

endmodule

// File: rtl/hpu_cand_loader.sv
// Buffers a batch of candidates for an external pivot tree and captures its winner.
// Optional build macro HPU_LOADER_ABS_EN stores saturating |s_val| instead of s_val.
module hpu_cand_loader
   import hpu_pkg::*;
#(
   parameter int unsigned DATA_W    = HPU_DATA_W,
   parameter int unsigned ROW_IDX_W = HPU_ROW_IDX_W,
   parameter int unsigned MAX_ELEMS = HPU_MAX_ELEMS
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             s_valid,
   output logic                             s_ready,
   input  logic signed [DATA_W-1:0]         s_val,
   input  logic [ROW_IDX_W-1:0]             s_row,
   input  logic                             s_last,
   input  logic                             s_flush,
   output logic signed [DATA_W-1:0]         cand_val [MAX_ELEMS],
   output logic [ROW_IDX_W-1:0]             cand_row [MAX_ELEMS],
   output logic [$clog2(MAX_ELEMS):0]       num_elems,
   input  logic [ROW_IDX_W-1:0]             pivot_row,
   input  logic signed [DATA_W-1:0]         pivot_value,
   input  logic                             pivot_valid,
   output logic                             res_valid,
   input  logic                             res_ready,
   output logic [ROW_IDX_W-1:0]             res_row,
   output logic signed [DATA_W-1:0]         res_value,
   output logic                             res_found,
   output logic                             res_overflow
);

   localparam int unsigned CNT_W = $clog2(MAX_ELEMS) + 1;
   localparam int unsigned IDX_W = $clog2(MAX_ELEMS);

   hpu_loader_state_e state_q, state_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic [ROW_IDX_W-1:0]  res_row_q, res_row_d;
   logic signed [DATA_W-1:0] res_value_q, res_value_d;
   logic                  res_found_q, res_found_d;
   logic                  res_ovf_q, res_ovf_d;
   logic                  wr_en;
   logic signed [DATA_W-1:0] wr_val;

`ifdef HPU_LOADER_ABS_EN
   hpu_abs_sat #(
      .DATA_W (DATA_W)
   ) u_abs_sat (
      .in_val  (s_val),
      .out_val (wr_val)
   );
`else
   assign wr_val = s_val;
`endif

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      res_row_d   = res_row_q;
      res_value_d = res_value_q;
      res_found_d = res_found_q;
      res_ovf_d   = res_ovf_q;
      wr_en       = 1'b0;
      s_ready     = 1'b0;
      unique case (state_q)
         StFill: begin
            s_ready = 1'b1;
            if (s_valid) begin
               if (count_q < CNT_W'(MAX_ELEMS)) begin
                  wr_en   = 1'b1;
                  count_d = count_q + CNT_W'(1);
               end else begin
                  ovf_d = 1'b1;
               end
            end
            // A beat sent together with s_flush is stored before the batch closes.
            if ((s_valid && s_last) || s_flush) begin
               state_d = StEval;
            end
         end
         StEval: begin
            res_row_d   = pivot_row;
            res_value_d = pivot_value;
            res_found_d = pivot_valid;
            res_ovf_d   = ovf_q;
            state_d     = StHold;
         end
         StHold: begin
            if (res_ready) begin
               count_d = '0;
               ovf_d   = 1'b0;
               state_d = StFill;
            end
         end
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StFill;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         res_row_q   <= '0;
         res_value_q <= '0;
         res_found_q <= 1'b0;
         res_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         res_row_q   <= res_row_d;
         res_value_q <= res_value_d;
         res_found_q <= res_found_d;
         res_ovf_q   <= res_ovf_d;
      end
   end

   // Storage is not reset; num_elems masks stale entries.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         cand_val[count_q[IDX_W-1:0]] <= wr_val;
         cand_row[count_q[IDX_W-1:0]] <= s_row;
      end
   end

   assign num_elems    = count_q;
   assign res_valid    = (state_q == StHold);
   assign res_row      = res_row_q;
   assign res_value    = res_value_q;
   assign res_found    = res_found_q;
   assign res_overflow = res_ovf_q;

endmodule

// File: doc/hpu_cand_loader.md
HPU_CAND_LOADER -- requirements
Module: hpu_cand_loader

Interface
- REQ-001 SHALL have parameter DATA_W, default 32, signed candidate value width.
- REQ-002 SHALL have parameter ROW_IDX_W, default 16, row index width.
- REQ-003 SHALL have parameter MAX_ELEMS, default 256, buffer depth; power of two.
- REQ-004 SHALL have ports:
  - clk  in  1  sole clock, rising edge.
  - rst  in  1  reset; synchronous, active-high.
  - s_valid  in  1  candidate beat valid.
  - s_ready  out  1  loader accepts beat.
  - s_val  in  DATA_W signed  candidate value.
  - s_row  in  ROW_IDX_W  candidate row.
  - s_last  in  1  beat is last of batch.
  - s_flush  in  1  end batch without data; sampled only when s_ready=1.
  - cand_val  out  DATA_W signed x MAX_ELEMS  stored values to pivot tree.
  - cand_row  out  ROW_IDX_W x MAX_ELEMS  stored rows to pivot tree.
  - num_elems  out  $clog2(MAX_ELEMS)+1  valid entry count to tree.
  - pivot_row  in  ROW_IDX_W  tree winner row.
  - pivot_value  in  DATA_W signed  tree winner value.
  - pivot_valid  in  1  tree winner valid.
  - res_valid  out  1  result available.
  - res_ready  in  1  consumer takes result.
  - res_row  out  ROW_IDX_W  captured pivot row.
  - res_value  out  DATA_W signed  captured pivot value.
  - res_found  out  1  captured pivot_valid.
  - res_overflow  out  1  batch exceeded MAX_ELEMS.

Function
- REQ-005 SHALL implement FSM states FILL, EVAL, HOLD.
- REQ-006 SHALL drive s_ready=1 only in FILL.
- REQ-007 SHALL, in FILL on s_valid&&s_ready with count<MAX_ELEMS, write s_val/s_row into entry [count] and increment count.
- REQ-008 SHALL, in FILL on an accepted beat with count==MAX_ELEMS, discard the beat, hold count, and set a sticky overflow flag.
- REQ-009 SHALL go FILL->EVAL on an accepted beat with s_last=1, or on s_flush=1 while in FILL.
- REQ-010 SHALL, when s_valid and s_flush are both high, store the beat first and then end the batch, exactly as for s_last=1.
- REQ-011 SHALL drive num_elems from the registered count, so it reflects every write from the previous cycle.
- REQ-012 SHALL, in EVAL, capture pivot_row, pivot_value, pivot_valid and the overflow flag into res_*, then go to HOLD; EVAL always lasts exactly one cycle.
- REQ-013 SHALL hold res_valid=1 and res_* stable in HOLD until res_ready=1.
- REQ-014 SHALL, on res_ready in HOLD, clear res_valid, clear count and overflow, and return to FILL; s_ready=1 on the next cycle.
- REQ-015 SHALL ignore res_ready outside HOLD.
- REQ-016 SHALL, for an empty batch (s_flush with count 0), report res_found=0 with num_elems=0.
- REQ-017 SHALL have latency: final beat accepted in cycle T -> EVAL in T+1 -> res_valid=1 in T+2.
- REQ-018 SHALL keep res_row and res_value unchanged outside EVAL.

Reset
- REQ-019 SHALL, on rst=1 at a clock edge, enter FILL from any state and drop any pending result or partial batch.
- REQ-020 SHALL, after reset, drive count=0, num_elems=0, res_valid=0, res_row=0, res_value=0, res_found=0, res_overflow=0, overflow flag 0, and s_ready=1.
- REQ-021 SHALL NOT reset the cand_val/cand_row storage; its content is don't-care while num_elems masks it.

Configuration
- REQ-022 SHALL, with HPU_LOADER_ABS_EN defined, store the saturating absolute value of s_val: the most negative value maps to the maximum positive value, and res_value is the stored absolute value.
- REQ-023 SHALL, without HPU_LOADER_ABS_EN, store s_val unmodified.

Structure
- REQ-024 SHALL take default widths HPU_DATA_W, HPU_ROW_IDX_W and HPU_MAX_ELEMS, and the FSM state enum typedef, from package hpu_pkg.
- REQ-025 SHALL place the abs/saturate logic in sub-module hpu_abs_sat, instantiated only under HPU_LOADER_ABS_EN.
- REQ-026 SHALL NOT instantiate the pivot tree; the tree connects externally via cand_*/num_elems/pivot_*.

Verification
- REQ-027 SHALL cover: beats (5,r0),(-9,r1),(7,r2,last) with signed-max tree -> num_elems=3, res_valid at T+2, res_row=r2, res_value=7, res_found=1.
- REQ-028 SHALL cover: s_flush with no beats -> res_found=0, num_elems=0, res_overflow=0.
- REQ-029 SHALL cover: MAX_ELEMS+3 beats, last on final beat -> num_elems=MAX_ELEMS, res_overflow=1, first MAX_ELEMS entries intact.
- REQ-030 SHALL cover: res_ready held low 10 cycles in HOLD -> res_* stable, s_ready=0; res_ready=1 -> s_ready=1 next cycle, num_elems=0.
- REQ-031 SHALL cover: rst asserted in EVAL and in HOLD -> next cycle FILL, res_valid=0, num_elems=0.
- REQ-032 SHALL cover: with HPU_LOADER_ABS_EN, beats (-100,r4),(50,r5,last) -> res_row=r4, res_value=100; beat 0x80000000 stores 0x7FFFFFFF.
